// File: rtl/raizing_sdram_pkg.sv
// raizing_sdram_pkg
// Shared types and constants for the Raizing SDRAM bank arbiter.
//   - arb_state_t : arbiter FSM states
//   - bank_t      : 2-bit SDRAM bank index
//   - NBANK       : number of requester channels / SDRAM banks
//   - REF_PERIOD_DEF : default refresh spacing in CLK cycles (7.8 us at 48 MHz)
package raizing_sdram_pkg;

    localparam int NBANK          = 4;
    localparam int REF_PERIOD_DEF = 374;

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        REFRESH
    } arb_state_t;

endpackage

// File: rtl/raizing_rr_pick.sv
// raizing_rr_pick
// Combinational round-robin picker: returns the first set request bit
// searching ptr+1, ptr+2, ... (mod NBANK), so the last winner ranks lowest.
//   req   in  NBANK  request vector
//   ptr   in  2      index of the previous winner
//   gnt   out 2      winning index (holds ptr when nothing is requested)
//   valid out 1      at least one request bit was set
module raizing_rr_pick import raizing_sdram_pkg::*; (
    input  logic [NBANK-1:0] req,
    input  bank_t            ptr,
    output bank_t            gnt,
    output logic             valid
);

    bank_t idx;

    // Walk from the farthest offset down to ptr+1 so the nearest candidate
    // is written last and wins.
    always_comb begin
        gnt   = ptr;
        valid = 1'b0;
        idx   = '0;
        for (int i = NBANK; i >= 1; i--) begin
            idx = ptr + bank_t'(i);
            if (req[idx]) begin
                gnt   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/raizing_sdram_bank_arb.sv
// raizing_sdram_bank_arb
// Puts the four Raizing ROM/RAM bank requesters onto the single jtframe SDRAM
// command port one transaction at a time, round-robin, and interleaves
// periodic auto-refresh. Core handshakes are routed back to the granted bank.
//
// Ports:
//   CLK, RESET                 clock, async active-high reset
//   BA_ADDR/BA_RD/BA_WR        per-bank address, level request, bank-0 write
//   BA0_DIN/BA0_DIN_M          bank-0 write data / byte mask (1 = masked)
//   BA_ACK/DST/DOK/RDY         handshakes returned to the granted bank only
//   SD_REQ/ADDR/BA/WE/DIN/DIN_M  latched command to the SDRAM core
//   SD_ACK/DST/DOK/RDY         core handshakes
//   REF_REQ/REF_ACK            refresh request / accept
//
// Build option: define RAIZING_ARB_PRIO_EN to give bank 0 fixed priority over
// the rotation (banks 1-3 still rotate among themselves).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no command outstanding; refresh first, else pick a bank
// REQ     | SD_REQ high with latched fields, waiting for SD_ACK
// DATA    | command accepted, waiting for SD_RDY
// REFRESH | REF_REQ high, waiting for REF_ACK
module raizing_sdram_bank_arb import raizing_sdram_pkg::*; #(
    parameter int AW           = 22,
    parameter int REF_PERIOD   = REF_PERIOD_DEF,
    parameter int REF_PEND_MAX = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [4*AW-1:0]     BA_ADDR,
    input  logic [NBANK-1:0]    BA_RD,
    input  logic                BA_WR,
    input  logic [15:0]         BA0_DIN,
    input  logic [1:0]          BA0_DIN_M,
    output logic [NBANK-1:0]    BA_ACK,
    output logic [NBANK-1:0]    BA_DST,
    output logic [NBANK-1:0]    BA_DOK,
    output logic [NBANK-1:0]    BA_RDY,
    output logic                SD_REQ,
    output logic [AW-1:0]       SD_ADDR,
    output bank_t               SD_BA,
    output logic                SD_WE,
    output logic [15:0]         SD_DIN,
    output logic [1:0]          SD_DIN_M,
    input  logic                SD_ACK,
    input  logic                SD_DST,
    input  logic                SD_DOK,
    input  logic                SD_RDY,
    output logic                REF_REQ,
    input  logic                REF_ACK
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int PW = $clog2(REF_PEND_MAX + 1);
    localparam logic [CW-1:0] REF_RELOAD = CW'(REF_PERIOD - 1);
    localparam logic [PW-1:0] PEND_MAX   = PW'(REF_PEND_MAX);

    arb_state_t       state, state_nx;
    bank_t            rr_ptr;
    logic [CW-1:0]    ref_cnt;
    logic [PW-1:0]    ref_pend;
    logic             grant_go;
    logic             ref_expire, ref_done;

    logic [NBANK-1:0] pick_req;
    bank_t            pick_gnt;
    logic             pick_vld;
    bank_t            grant_bank;
    logic             grant_vld;
    logic             ptr_upd;
    logic [NBANK-1:0] gnt_onehot;

`ifdef RAIZING_ARB_PRIO_EN
    // Bank 0 bypasses the rotation; leaving rr_ptr alone on a bank-0 win
    // keeps the 1-3 rotation where it was.
    assign pick_req   = {BA_RD[3:1], 1'b0};
    assign grant_bank = BA_RD[0] ? bank_t'(0) : pick_gnt;
    assign grant_vld  = BA_RD[0] | pick_vld;
    assign ptr_upd    = !BA_RD[0];
`else
    assign pick_req   = BA_RD;
    assign grant_bank = pick_gnt;
    assign grant_vld  = pick_vld;
    assign ptr_upd    = 1'b1;
`endif

    raizing_rr_pick u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_vld)
    );

    always_comb begin
        state_nx = state;
        grant_go = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend != '0) begin
                    state_nx = REFRESH;
                end else if (grant_vld) begin
                    state_nx = REQ;
                    grant_go = 1'b1;
                end
            end
            REQ:     if (SD_ACK)  state_nx = DATA;
            DATA:    if (SD_RDY)  state_nx = IDLE;
            REFRESH: if (REF_ACK) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            rr_ptr   <= bank_t'(3);
            SD_ADDR  <= '0;
            SD_BA    <= '0;
            SD_WE    <= 1'b0;
            SD_DIN   <= '0;
            SD_DIN_M <= '0;
        end else begin
            state <= state_nx;
            if (grant_go) begin
                if (ptr_upd) rr_ptr <= grant_bank;
                SD_ADDR  <= BA_ADDR[grant_bank*AW +: AW];
                SD_BA    <= grant_bank;
                SD_WE    <= BA_WR & (grant_bank == bank_t'(0));
                SD_DIN   <= BA0_DIN;
                SD_DIN_M <= BA0_DIN_M;
            end
        end
    end

    // An expiry that lands on the same cycle as a REF_ACK cancels out, even
    // when the owed count is already saturated.
    assign ref_expire = (ref_cnt == '0);
    assign ref_done   = (state == REFRESH) && REF_ACK;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ref_cnt  <= REF_RELOAD;
            ref_pend <= '0;
        end else begin
            ref_cnt <= ref_expire ? REF_RELOAD : ref_cnt - CW'(1);
            if (ref_expire && !ref_done && ref_pend != PEND_MAX)
                ref_pend <= ref_pend + PW'(1);
            else if (ref_done && !ref_expire)
                ref_pend <= ref_pend - PW'(1);
        end
    end

    // SD_REQ/REF_REQ decode the registered state, so they rise the cycle
    // after the decision and fall the cycle after the core's accept.
    assign SD_REQ  = (state == REQ);
    assign REF_REQ = (state == REFRESH);

    always_comb begin
        gnt_onehot = '0;
        if (state == REQ || state == DATA) gnt_onehot[SD_BA] = 1'b1;
    end

    assign BA_ACK = {NBANK{SD_ACK}} & gnt_onehot;
    assign BA_DST = {NBANK{SD_DST}} & gnt_onehot;
    assign BA_DOK = {NBANK{SD_DOK}} & gnt_onehot;
    assign BA_RDY = {NBANK{SD_RDY}} & gnt_onehot;

endmodule

// File: tb/tb_raizing_sdram_bank_arb.sv
module tb_raizing_sdram_bank_arb;

    localparam int AW = 22;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [4*AW-1:0] BA_ADDR;
    logic [3:0]      BA_RD;
    logic            BA_WR;
    logic [15:0]     BA0_DIN;
    logic [1:0]      BA0_DIN_M;
    logic [3:0]      BA_ACK, BA_DST, BA_DOK, BA_RDY;
    logic            SD_REQ, SD_WE, REF_REQ;
    logic [AW-1:0]   SD_ADDR;
    logic [1:0]      SD_BA, SD_DIN_M;
    logic [15:0]     SD_DIN;
    logic            SD_ACK, SD_DST, SD_DOK, SD_RDY, REF_ACK;

    // second instance with a short refresh period
    logic [3:0]      r_ba_ack, r_ba_dst, r_ba_dok, r_ba_rdy;
    logic            r_sd_req, r_sd_we, r_ref_req;
    logic [AW-1:0]   r_sd_addr;
    logic [1:0]      r_sd_ba, r_sd_din_m;
    logic [15:0]     r_sd_din;
    logic            r_sd_ack, r_sd_dst, r_sd_dok, r_sd_rdy, r_ref_ack;

    int errors = 0;
    int checks = 0;
    int ph, wt, ref_at, bad, rounds, got_req, n;
    logic [3:0] exp_seq [4];

    always #5 CLK = ~CLK;

    raizing_sdram_bank_arb #(.AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .BA_ADDR(BA_ADDR), .BA_RD(BA_RD), .BA_WR(BA_WR),
        .BA0_DIN(BA0_DIN), .BA0_DIN_M(BA0_DIN_M),
        .BA_ACK(BA_ACK), .BA_DST(BA_DST), .BA_DOK(BA_DOK), .BA_RDY(BA_RDY),
        .SD_REQ(SD_REQ), .SD_ADDR(SD_ADDR), .SD_BA(SD_BA), .SD_WE(SD_WE),
        .SD_DIN(SD_DIN), .SD_DIN_M(SD_DIN_M),
        .SD_ACK(SD_ACK), .SD_DST(SD_DST), .SD_DOK(SD_DOK), .SD_RDY(SD_RDY),
        .REF_REQ(REF_REQ), .REF_ACK(REF_ACK)
    );

    raizing_sdram_bank_arb #(.AW(AW), .REF_PERIOD(16), .REF_PEND_MAX(3)) dut_r (
        .CLK(CLK), .RESET(RESET), .BA_ADDR(BA_ADDR), .BA_RD(BA_RD), .BA_WR(BA_WR),
        .BA0_DIN(BA0_DIN), .BA0_DIN_M(BA0_DIN_M),
        .BA_ACK(r_ba_ack), .BA_DST(r_ba_dst), .BA_DOK(r_ba_dok), .BA_RDY(r_ba_rdy),
        .SD_REQ(r_sd_req), .SD_ADDR(r_sd_addr), .SD_BA(r_sd_ba), .SD_WE(r_sd_we),
        .SD_DIN(r_sd_din), .SD_DIN_M(r_sd_din_m),
        .SD_ACK(r_sd_ack), .SD_DST(r_sd_dst), .SD_DOK(r_sd_dok), .SD_RDY(r_sd_rdy),
        .REF_REQ(r_ref_req), .REF_ACK(r_ref_ack)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int b, input logic [AW-1:0] a);
        BA_ADDR[b*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] addr_of(input int b);
        return AW'(32'h100 + b * 32'h111);
    endfunction

    task automatic do_reset();
        SD_ACK = 0; SD_DST = 0; SD_DOK = 0; SD_RDY = 0; REF_ACK = 0;
        r_sd_ack = 0; r_sd_dst = 0; r_sd_dok = 0; r_sd_rdy = 0; r_ref_ack = 0;
        BA_RD = 4'b0000;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // One full transaction on dut: SD_ACK two cycles after SD_REQ, SD_RDY a
    // few cycles later; BA_RD switches to rd_after once the grant is visible.
    task automatic txn(input int b, input logic [AW-1:0] a, input logic [3:0] rd_after,
                       input string tag);
        int cnt;
        logic [3:0] oh;
        cnt = 0;
        oh  = 4'(1 << b);
        while (SD_REQ !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        BA_RD = rd_after;
        check({tag, "_req"},  32'(SD_REQ), 32'd1);
        check({tag, "_ba"},   32'(SD_BA), 32'(b));
        check({tag, "_addr"}, 32'(SD_ADDR), 32'(a));
        tick();
        tick();
        check({tag, "_hold"}, 32'({SD_REQ, SD_ADDR}), 32'({1'b1, a}));
        SD_ACK = 1'b1;
        #1;
        check({tag, "_ack"}, 32'(BA_ACK), 32'(oh));
        tick();
        SD_ACK = 1'b0;
        check({tag, "_reqdrop"}, 32'(SD_REQ), 32'd0);
        SD_DST = 1'b1;
        #1;
        check({tag, "_dst"}, 32'(BA_DST), 32'(oh));
        tick();
        SD_DST = 1'b0;
        SD_DOK = 1'b1;
        #1;
        check({tag, "_dok"}, 32'(BA_DOK), 32'(oh));
        tick();
        SD_DOK = 1'b0;
        tick();
        SD_RDY = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(BA_RDY), 32'(oh));
        tick();
        SD_RDY = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        BA_ADDR = '0; BA_RD = 4'b0000; BA_WR = 1'b0; BA0_DIN = '0; BA0_DIN_M = '0;
        SD_ACK = 0; SD_DST = 0; SD_DOK = 0; SD_RDY = 0; REF_ACK = 0;
        r_sd_ack = 0; r_sd_dst = 0; r_sd_dok = 0; r_sd_rdy = 0; r_ref_ack = 0;
        #12;
        check("rst_req",  32'({SD_REQ, REF_REQ, SD_WE}), 32'd0);
        check("rst_addr", 32'(SD_ADDR), 32'd0);
        check("rst_fld",  32'({SD_BA, SD_DIN, SD_DIN_M}), 32'd0);
        check("rst_ba",   32'({BA_ACK, BA_DST, BA_DOK, BA_RDY}), 32'd0);

        // round-robin with all four banks requesting, wrap 3 -> 0
        do_reset();
        for (int b = 0; b < 4; b++) set_addr(b, addr_of(b));
        BA_RD = 4'b1111;
        for (int k = 0; k < 5; k++)
            txn(k % 4, addr_of(k % 4), 4'b1111, $sformatf("rr%0d", k));

        // stray core handshakes in IDLE are dropped
        do_reset();
        SD_ACK = 1; SD_DST = 1; SD_DOK = 1; SD_RDY = 1;
        #1;
        check("stray_idle", 32'({BA_ACK, BA_DST, BA_DOK, BA_RDY}), 32'd0);
        tick();
        check("stray_noreq", 32'(SD_REQ), 32'd0);
        SD_ACK = 0; SD_DST = 0; SD_DOK = 0; SD_RDY = 0;

        // bank 1 drops its request after grant; latched address holds
        do_reset();
        set_addr(1, 22'h12345);
        BA_RD = 4'b0010;
        n = 0;
        while (SD_REQ !== 1'b1 && n < 20) begin tick(); n++; end
        check("drop_addr0", 32'(SD_ADDR), 32'h12345);
        BA_RD = 4'b0000;
        set_addr(1, 22'h0ABCD);
        tick();
        check("drop_hold", 32'({SD_REQ, SD_ADDR}), 32'({1'b1, 22'h12345}));
        SD_ACK = 1'b1;
        #1;
        check("drop_ack", 32'(BA_ACK), 32'h2);
        tick();
        SD_ACK = 1'b0;
        SD_RDY = 1'b1;
        #1;
        check("drop_rdy", 32'(BA_RDY), 32'h2);
        tick();
        SD_RDY = 1'b0;
        tick();
        tick();
        check("drop_idle", 32'(SD_REQ), 32'd0);

        // write qualifier honoured for bank 0 only
        do_reset();
        set_addr(2, 22'h00222);
        set_addr(0, 22'h3F000);
        BA_WR = 1'b1;
        BA0_DIN = 16'hBEEF;
        BA0_DIN_M = 2'b01;
        BA_RD = 4'b0100;
        txn(2, 22'h00222, 4'b0001, "wr_b2");
        check("wr_b2_we", 32'(SD_WE), 32'd0);
        txn(0, 22'h3F000, 4'b0000, "wr_b0");
        check("wr_b0_we", 32'(SD_WE), 32'd1);
        check("wr_b0_din", 32'({SD_DIN_M, SD_DIN}), 32'({2'b01, 16'hBEEF}));
        BA_WR = 1'b0;

        // refresh with period 16 against a continuous bank 1 stream
        do_reset();
        set_addr(1, 22'h02222);
        BA_RD = 4'b0010;
        ph = 0; wt = 0; ref_at = -1; bad = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (r_ref_req && (r_sd_req || ph != 0)) bad++;
            r_sd_ack = 1'b0;
            r_sd_rdy = 1'b0;
            if (r_ref_req) begin
                ref_at = c;
                break;
            end
            if (ph == 0) begin
                if (r_sd_req) begin r_sd_ack = 1'b1; ph = 1; wt = 3; end
            end else begin
                wt--;
                if (wt == 0) begin r_sd_rdy = 1'b1; ph = 0; end
            end
        end
        check("refA_seen",  32'(ref_at > 0), 32'd1);
        check("refA_time",  32'(ref_at <= 26), 32'd1);
        check("refA_excl",  32'(bad), 32'd0);
        check("refA_nosd",  32'(r_sd_req), 32'd0);
        r_ref_ack = 1'b1;
        tick();
        r_ref_ack = 1'b0;
        check("refA_drop",  32'(r_ref_req), 32'd0);
        tick();
        check("refA_resume", 32'({r_sd_req, r_sd_ba}), 32'({1'b1, 2'd1}));

        // refresh debt saturates at 3 while REF_ACK is held low
        do_reset();
        for (int c = 0; c < 66; c++) tick();
        r_sd_ack = 1'b1;
        #1;
        check("refB_stray", 32'({r_ba_ack, r_ref_req}), 32'({4'b0000, 1'b1}));
        r_sd_ack = 1'b0;
        BA_RD = 4'b0010;
        rounds = 0; got_req = 0;
        for (int c = 0; c < 30; c++) begin
            if (r_sd_req) begin
                got_req = 1;
                break;
            end
            if (r_ref_req) begin
                rounds++;
                r_ref_ack = 1'b1;
            end else begin
                r_ref_ack = 1'b0;
            end
            tick();
        end
        r_ref_ack = 1'b0;
        check("refB_rounds", 32'(rounds), 32'd3);
        check("refB_grant",  32'({got_req[0], r_sd_ba}), 32'({1'b1, 2'd1}));

        // reset during DATA aborts immediately; pointer returns to 3
        do_reset();
        set_addr(1, 22'h01111);
        set_addr(3, 22'h03333);
        set_addr(0, 22'h00AAA);
        BA_RD = 4'b0010;
        n = 0;
        while (SD_REQ !== 1'b1 && n < 20) begin tick(); n++; end
        SD_ACK = 1'b1;
        tick();
        SD_ACK = 1'b0;
        SD_DOK = 1'b1;
        #1;
        check("mid_dok", 32'(BA_DOK), 32'h2);
        RESET = 1'b1;
        #1;
        check("mid_rst_ba",  32'({BA_ACK, BA_DST, BA_DOK, BA_RDY}), 32'd0);
        check("mid_rst_req", 32'({SD_REQ, REF_REQ, SD_BA}), 32'd0);
        check("mid_rst_addr", 32'(SD_ADDR), 32'd0);
        SD_DOK = 1'b0;
        tick();
        RESET = 1'b0;
        BA_RD = 4'b1010;
        txn(1, 22'h01111, 4'b0011, "post_rst");
`ifdef RAIZING_ARB_PRIO_EN
        exp_seq = '{4'd0, 4'd0, 4'd0, 4'd0};
`else
        exp_seq = '{4'd0, 4'd1, 4'd0, 4'd1};
`endif
        set_addr(1, 22'h01111);
        for (int k = 0; k < 4; k++)
            txn(int'(exp_seq[k]), (exp_seq[k] == 4'd0) ? 22'h00AAA : 22'h01111,
                4'b0011, $sformatf("pair%0d", k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
